// File: rtl/wb_scan_bridge.sv
// wb_scan_bridge: Wishbone slave that turns each bus access into a four-phase
// req/ack transaction on the scan chain. The host ack is synchronised, the bus
// ack is a single-cycle pulse, and requests the host never answers time out.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request pending; accepts a new access once host ack is low
// REQ     | o_scan_cyc high, fields frozen, waiting for host ack or timeout
// RELEASE | bus ack pulse is high for this one cycle; clear it and rdt
// DRAIN   | wait for the host to drop its ack before the next request
module wb_scan_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_scan_adr,
  output logic [31:0] o_scan_dat,
  output logic [3:0]  o_scan_sel,
  output logic        o_scan_we,
  output logic        o_scan_cyc,
  input  logic [31:0] i_scan_rdt,
  input  logic        i_scan_ack,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  // Timeout fires on the REQ cycle whose counter equals TIMEOUT_CYCLES-1.
  localparam bit          LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LP_TC_LAST = LP_TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ack_meta;
  logic        r_ack_s;
  logic [31:0] r_cnt;
  logic [31:0] r_wb_rdt;
  logic        r_wb_ack;
  logic [31:0] r_scan_adr;
  logic [31:0] r_scan_dat;
  logic [3:0]  r_scan_sel;
  logic        r_scan_we;
  logic        r_scan_cyc;
  logic        r_timeout;
  logic        w_accept;
  logic        w_timeout_hit;

  // A stale host ack (still high after reset or a timeout) blocks acceptance.
  assign w_accept      = (r_state == S_IDLE) && i_wb_cyc && !r_ack_s && !r_wb_ack;
  assign w_timeout_hit = LP_TO_EN && (r_cnt == LP_TC_LAST);

  // Two-flop synchroniser for the asynchronous host ack level.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= i_scan_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; ack beats timeout when both are true in REQ.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_REQ;
      S_REQ:     if (r_ack_s || w_timeout_hit) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_DRAIN;
      S_DRAIN:   if (!r_ack_s) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Request latching, completion data, bus ack pulse, timeout counter and flag.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_wb_rdt   <= '0;
      r_wb_ack   <= 1'b0;
      r_scan_adr <= '0;
      r_scan_dat <= '0;
      r_scan_sel <= '0;
      r_scan_we  <= 1'b0;
      r_scan_cyc <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_scan_adr <= i_wb_adr;
            r_scan_dat <= i_wb_dat;
            r_scan_sel <= i_wb_sel;
            r_scan_we  <= i_wb_we;
            r_scan_cyc <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_REQ: begin
          if (r_ack_s) begin
            // Host data is stable while its ack is high, so no sync is needed here.
            r_wb_rdt   <= r_scan_we ? 32'd0 : i_scan_rdt;
            r_wb_ack   <= i_wb_cyc;
            r_scan_cyc <= 1'b0;
          end else if (w_timeout_hit) begin
            r_wb_rdt   <= TIMEOUT_DATA;
            r_wb_ack   <= i_wb_cyc;
            r_timeout  <= 1'b1;
            r_scan_cyc <= 1'b0;
          end else if (r_cnt != 32'hFFFF_FFFF) begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RELEASE: begin
          r_wb_ack <= 1'b0;
          r_wb_rdt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_wb_rdt   = r_wb_rdt;
  assign o_wb_ack   = r_wb_ack;
  assign o_scan_adr = r_scan_adr;
  assign o_scan_dat = r_scan_dat;
  assign o_scan_sel = r_scan_sel;
  assign o_scan_we  = r_scan_we;
  assign o_scan_cyc = r_scan_cyc;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_wb_scan_bridge.sv
// Directed bench for wb_scan_bridge with a 16-cycle timeout.
module tb_wb_scan_bridge;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_wb_adr, i_wb_dat, i_scan_rdt;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we, i_wb_cyc, i_scan_ack;
  logic [31:0] o_wb_rdt, o_scan_adr, o_scan_dat;
  logic [3:0]  o_scan_sel;
  logic        o_wb_ack, o_scan_we, o_scan_cyc, o_timeout;

  int n_checks = 0;
  int n_err    = 0;
  int ack_cnt  = 0;

  wb_scan_bridge #(.TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .i_rst(i_rst),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .o_scan_adr(o_scan_adr), .o_scan_dat(o_scan_dat), .o_scan_sel(o_scan_sel),
    .o_scan_we(o_scan_we), .o_scan_cyc(o_scan_cyc),
    .i_scan_rdt(i_scan_rdt), .i_scan_ack(i_scan_ack),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Bus ack pulses: sampled at the rising edge, before the flops update.
  always @(posedge clk) if (o_wb_ack) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Negedges until o_wb_ack is seen high (100 means it never came).
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_wb_ack && n < 100);
  endtask

  // Negedges until o_scan_cyc is seen high (100 means it never came).
  task automatic wait_scan(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_scan_cyc && n < 100);
  endtask

  task automatic bus_req(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we; i_wb_cyc = 1'b1;
  endtask

  initial begin
    int n, base, seen;
    i_rst = 1'b1; i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0;
    i_wb_cyc = 1'b0; i_scan_rdt = '0; i_scan_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    check("rst_rdt", o_wb_rdt, 32'd0);
    check("rst_scan_cyc", {31'd0, o_scan_cyc}, 32'd0);
    check("rst_scan_adr", o_scan_adr, 32'd0);
    check("rst_timeout", {31'd0, o_timeout}, 32'd0);
    i_rst = 1'b0;
    @(negedge clk);

    // 1: read, host answers 5 cycles after the request appears
    bus_req(32'h100, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    check("t1_scan_cyc", {31'd0, o_scan_cyc}, 32'd1);
    check("t1_scan_adr", o_scan_adr, 32'h100);
    check("t1_scan_we", {31'd0, o_scan_we}, 32'd0);
    seen = 0;
    repeat (5) begin @(negedge clk); if (o_wb_ack) seen++; end
    check("t1_no_early_ack", seen, 0);
    i_scan_rdt = 32'h12345678; i_scan_ack = 1'b1;
    base = ack_cnt;
    wait_ack(n);
    check("t1_latency", n, 3);
    check("t1_rdt", o_wb_rdt, 32'h12345678);
    check("t1_scan_cyc_low", {31'd0, o_scan_cyc}, 32'd0);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    check("t1_pulse_end", {31'd0, o_wb_ack}, 32'd0);
    check("t1_rdt_clear", o_wb_rdt, 32'd0);
    i_scan_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("t1_one_pulse", ack_cnt - base, 1);

    // 2: write, fields stay frozen through REQ, rdt returned as zero
    bus_req(32'h200, 32'hA5A5A5A5, 4'b0011, 1'b1);
    @(negedge clk);
    i_wb_adr = 32'hFFFF0000; i_wb_dat = 32'h0; i_wb_sel = 4'hC; i_wb_we = 1'b0;
    i_scan_rdt = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check("t2_scan_adr", o_scan_adr, 32'h200);
    check("t2_scan_dat", o_scan_dat, 32'hA5A5A5A5);
    check("t2_scan_sel", {28'd0, o_scan_sel}, 32'h3);
    check("t2_scan_we", {31'd0, o_scan_we}, 32'd1);
    i_scan_ack = 1'b1;
    wait_ack(n);
    check("t2_latency", n, 3);
    check("t2_rdt", o_wb_rdt, 32'd0);
    check("t2_scan_dat_hold", o_scan_dat, 32'hA5A5A5A5);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    check("t2_pulse_end", {31'd0, o_wb_ack}, 32'd0);
    i_scan_ack = 1'b0;
    repeat (4) @(negedge clk);

    // 3: timeout with a silent host, then a late host ack
    base = ack_cnt;
    bus_req(32'h300, 32'h0, 4'hF, 1'b0);
    wait_ack(n);
    check("t3_timeout_edge", n, 17);
    check("t3_rdt", o_wb_rdt, 32'hDEADBEEF);
    check("t3_timeout_flag", {31'd0, o_timeout}, 32'd1);
    check("t3_scan_cyc_low", {31'd0, o_scan_cyc}, 32'd0);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    check("t3_pulse_end", {31'd0, o_wb_ack}, 32'd0);
    repeat (2) @(negedge clk);
    i_scan_ack = 1'b1; i_scan_rdt = 32'h5555AAAA;
    repeat (6) @(negedge clk);
    check("t3_late_ack_absorbed", ack_cnt - base, 1);
    check("t3_timeout_sticky", {31'd0, o_timeout}, 32'd1);
    i_scan_ack = 1'b0;
    repeat (4) @(negedge clk);

    // 4: back-to-back, host holds ack for 10 cycles
    base = ack_cnt;
    bus_req(32'h400, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    i_scan_rdt = 32'h11111111; i_scan_ack = 1'b1;
    wait_ack(n);
    check("t4a_latency", n, 3);
    check("t4a_rdt", o_wb_rdt, 32'h11111111);
    bus_req(32'h404, 32'h0, 4'hF, 1'b0);
    seen = 0;
    repeat (7) begin @(negedge clk); if (o_scan_cyc) seen++; end
    check("t4_no_early_reissue", seen, 0);
    i_scan_ack = 1'b0;
    wait_scan(n);
    check("t4_reissue_delay", n, 4);
    check("t4b_scan_adr", o_scan_adr, 32'h404);
    i_scan_rdt = 32'h22222222; i_scan_ack = 1'b1;
    wait_ack(n);
    check("t4b_latency", n, 3);
    check("t4b_rdt", o_wb_rdt, 32'h22222222);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    i_scan_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_two_pulses", ack_cnt - base, 2);

    // 6: master drops cyc during REQ, host still completes the handshake
    base = ack_cnt;
    bus_req(32'h500, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    check("t6_scan_cyc", {31'd0, o_scan_cyc}, 32'd1);
    i_wb_cyc = 1'b0;
    i_scan_rdt = 32'h33333333; i_scan_ack = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_ack", ack_cnt - base, 0);
    check("t6_scan_cyc_low", {31'd0, o_scan_cyc}, 32'd0);
    i_scan_ack = 1'b0;
    repeat (4) @(negedge clk);
    bus_req(32'h600, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    check("t6_back_to_idle", {31'd0, o_scan_cyc}, 32'd1);
    check("t6_next_adr", o_scan_adr, 32'h600);

    // 5: reset while in REQ, then a stale host ack out of reset
    i_rst = 1'b1;
    #1;
    check("t5_rst_scan_cyc", {31'd0, o_scan_cyc}, 32'd0);
    check("t5_rst_scan_adr", o_scan_adr, 32'd0);
    check("t5_rst_timeout", {31'd0, o_timeout}, 32'd0);
    i_wb_cyc = 1'b0; i_scan_ack = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    bus_req(32'h700, 32'h0, 4'hF, 1'b0);
    seen = 0;
    repeat (5) begin @(negedge clk); if (o_scan_cyc) seen++; end
    check("t5_stale_ack_blocks", seen, 0);
    i_scan_ack = 1'b0;
    wait_scan(n);
    check("t5_accept_delay", n, 3);
    check("t5_scan_adr", o_scan_adr, 32'h700);
    i_scan_rdt = 32'h44444444; i_scan_ack = 1'b1;
    wait_ack(n);
    check("t5_latency", n, 3);
    check("t5_rdt", o_wb_rdt, 32'h44444444);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    i_scan_ack = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
